// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcodes, fetch FSM states and fetch defaults.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, branch redirect and decode handshake.
interface instr_fetch_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [N-1:0] imem_rdata;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         inst_valid;
    logic         inst_ready;
    logic [N-1:0] inst_out;
    logic [N-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry in-order fetch queue: entries are allocated at grant, filled by responses
// in allocation order, and popped from the head once filled.
module fetch_buffer #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         alloc_i,
    input  logic [N-1:0] alloc_pc_i,
    input  logic         fill_i,
    input  logic [N-1:0] fill_data_i,
    input  logic         pop_i,
    output logic         head_filled_o,
    output logic [N-1:0] head_pc_o,
    output logic [N-1:0] head_inst_o,
    output logic [1:0]   alloc_cnt_o,
    output logic [1:0]   unfilled_cnt_o
);

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] inst;
        logic         filled;
    } entry_t;

    entry_t     ent_q [DEPTH];
    entry_t     ent_d [DEPTH];
    logic [1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] pending;

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        // Fill the oldest unfilled entry before the pop shifts the queue.
        if (fill_i) begin
            if (cnt_d != 2'd0 && !ent_d[0].filled) begin
                ent_d[0].inst   = fill_data_i;
                ent_d[0].filled = 1'b1;
            end else if (cnt_d == 2'd2 && !ent_d[1].filled) begin
                ent_d[1].inst   = fill_data_i;
                ent_d[1].filled = 1'b1;
            end
        end
        if (pop_i && cnt_d != 2'd0) begin
            ent_d[0] = ent_d[1];
            ent_d[1] = '0;
            cnt_d    = cnt_d - 2'd1;
        end
        if (alloc_i && cnt_d != 2'd2) begin
            if (cnt_d == 2'd0) begin
                ent_d[0] = '{pc: alloc_pc_i, inst: '0, filled: 1'b0};
            end else begin
                ent_d[1] = '{pc: alloc_pc_i, inst: '0, filled: 1'b0};
            end
            cnt_d = cnt_d + 2'd1;
        end
        if (clear_i) begin
            ent_d[0] = '0;
            ent_d[1] = '0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q[0] <= ent_d[0];
            ent_q[1] <= ent_d[1];
            cnt_q    <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pending
        assign pending[gi] = (2'(gi) < cnt_q) && !ent_q[gi].filled;
    end

    assign unfilled_cnt_o = {1'b0, pending[0]} + {1'b0, pending[1]};
    assign alloc_cnt_o    = cnt_q;
    assign head_filled_o  = ent_q[0].filled;
    assign head_pc_o      = ent_q[0].filled ? ent_q[0].pc   : '0;
    assign head_inst_o    = ent_q[0].filled ? ent_q[0].inst : '0;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory request issue, redirect squash and decode hand-off.
// Define IFETCH_PERF_CNT_EN to add the stall_cnt output (cycles out of BOOT with no valid instruction).
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int          N        = XLEN,
    parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    instr_fetch_if.master   bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [1:0]   drop_q, drop_d;
    logic         grant, pop, fill, drop_rsp, rsp_tracked;
    logic [1:0]   alloc_cnt, unfilled_cnt, in_flight;
    logic         head_filled;
    logic [N-1:0] head_pc, head_inst;

    assign bus.imem_req  = (state_q != ST_BOOT) && (({1'b0, alloc_cnt} + {1'b0, drop_q}) < 3'd2);
    assign bus.imem_addr = pc_q;

    assign grant       = bus.imem_req && bus.imem_gnt;
    assign pop         = head_filled && bus.inst_ready;
    assign drop_rsp    = bus.imem_rvalid && (drop_q != 2'd0);
    assign fill        = bus.imem_rvalid && (drop_q == 2'd0) && !bus.redirect_valid;
    assign rsp_tracked = bus.imem_rvalid && ((drop_q != 2'd0) || (unfilled_cnt != 2'd0));
    // Requests still owed a response once a redirect cycle completes; all become drops.
    assign in_flight   = drop_q + unfilled_cnt + {1'b0, grant} - {1'b0, rsp_tracked};

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        state_d = state_q;
        if (bus.redirect_valid) begin
            pc_d   = {bus.redirect_pc[N-1:2], 2'b00};
            drop_d = in_flight;
        end else begin
            if (grant) begin
                pc_d = pc_q + N'(4);
            end
            if (drop_rsp) begin
                drop_d = drop_q - 2'd1;
            end
        end
        unique case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (bus.redirect_valid && drop_d != 2'd0) state_d = ST_FLUSH;
            ST_FLUSH: if (drop_d == 2'd0) state_d = ST_FETCH;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    fetch_buffer #(.N(N)) u_fetch_buffer (
        .clk            (clk),
        .reset          (reset),
        .clear_i        (bus.redirect_valid),
        .alloc_i        (grant),
        .alloc_pc_i     (pc_q),
        .fill_i         (fill),
        .fill_data_i    (bus.imem_rdata),
        .pop_i          (pop),
        .head_filled_o  (head_filled),
        .head_pc_o      (head_pc),
        .head_inst_o    (head_inst),
        .alloc_cnt_o    (alloc_cnt),
        .unfilled_cnt_o (unfilled_cnt)
    );

    assign bus.inst_valid = head_filled;
    assign bus.inst_out   = head_inst;
    assign bus.inst_pc    = head_pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (state_q != ST_BOOT && !head_filled) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch against a transaction-level model of the fetch stream.
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_if #(.N(32)) bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    instr_fetch #(.N(32), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        mem_q [$];
    ent_t        buf_q [$];
    logic [31:0] fetch_pc;
    logic [31:0] stall_exp;
    int          epoch;
    int          cyc;
    bit          boot;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset              = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        mem_q.delete();
        buf_q.delete();
        fetch_pc  = RST_PC;
        stall_exp = 32'd0;
        epoch++;
        boot = 1'b1;
        cyc++;
        $display("reset applied at cycle %0d", cyc);
    endtask

    // mode 0: ideal memory; 1: random; 2: decode stalled; 3: no grants; 4: grants, no responses
    task automatic step(input int mode, input bit do_redirect, input logic [31:0] tgt);
        bit          gnt, rv, rdy, req_exp, can_rsp;
        int          occ;
        req_t        r;
        logic [31:0] rd;
        @(negedge clk);
        reset   = 1'b0;
        occ     = mem_q.size() + buf_q.size();
        req_exp = !boot && (occ < 2);
        check_eq("imem_req", {31'b0, bus.imem_req}, {31'b0, req_exp});
        check_eq("imem_addr", bus.imem_addr, fetch_pc);
        check_eq("inst_valid", {31'b0, bus.inst_valid}, {31'b0, buf_q.size() > 0});
        if (buf_q.size() > 0) begin
            check_eq("inst_pc", bus.inst_pc, buf_q[0].pc);
            check_eq("inst_out", bus.inst_out, buf_q[0].data);
        end else begin
            check_eq("inst_pc_idle", bus.inst_pc, 32'h0);
            check_eq("inst_out_idle", bus.inst_out, 32'h0);
        end
`ifdef IFETCH_PERF_CNT_EN
        check_eq("stall_cnt", stall_cnt, stall_exp);
`endif
        can_rsp = (mem_q.size() > 0) && (mem_q[0].cyc < cyc);
        case (mode)
            0:       begin gnt = 1'b1; rdy = 1'b1; rv = can_rsp; end
            1:       begin
                         gnt = ($urandom_range(0, 3) != 0);
                         rdy = ($urandom_range(0, 3) != 0);
                         rv  = can_rsp && ($urandom_range(0, 2) != 0);
                     end
            2:       begin gnt = 1'b1; rdy = 1'b0; rv = can_rsp; end
            3:       begin gnt = 1'b0; rdy = 1'b1; rv = can_rsp; end
            default: begin gnt = 1'b1; rdy = 1'b1; rv = 1'b0; end
        endcase
        rd = rv ? mem_word(mem_q[0].addr) : $urandom;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rd;
        bus.inst_ready     = rdy;
        bus.redirect_valid = do_redirect;
        bus.redirect_pc    = do_redirect ? tgt : $urandom;

        if (!boot && buf_q.size() == 0) stall_exp = stall_exp + 32'd1;
        if (buf_q.size() > 0 && rdy) begin
            $display("deliver pc=%h inst=%h", buf_q[0].pc, buf_q[0].data);
            void'(buf_q.pop_front());
        end
        if (rv) begin
            r = mem_q.pop_front();
            if (!do_redirect && r.epoch == epoch) buf_q.push_back('{pc: r.addr, data: rd});
        end
        if (req_exp && gnt) mem_q.push_back('{addr: fetch_pc, epoch: epoch, cyc: cyc});
        if (do_redirect) begin
            $display("redirect to %h at cycle %0d", tgt, cyc);
            buf_q.delete();
            epoch++;
            fetch_pc = {tgt[31:2], 2'b00};
        end else if (req_exp && gnt) begin
            fetch_pc = fetch_pc + 32'd4;
        end
        boot = 1'b0;
        cyc++;
    endtask

    initial begin
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        epoch = 0;
        cyc   = 0;

        // Ideal streaming across the address wrap, then decode back-pressure.
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++)  step(2, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0);

        // Two requests in flight when redirecting to 0x100.
        for (int i = 0; i < 6; i++)  step(3, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)  step(4, 1'b0, 32'h0);
        step(4, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0);

        // Redirect coinciding with a grant and a response; low target bits are ignored.
        step(0, 1'b1, 32'h0000_0203);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0);

        // Grants withheld for 10 cycles after BOOT.
        do_reset();
        step(3, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(3, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0);

        // Random traffic with occasional redirects and one mid-run reset.
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step(1, (i != 400) && ($urandom_range(0, 19) == 0), $urandom);
        end
        for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
